vita_tx_pkt_checker: RTL

//  Store-and-forward fifo36 packet checker, upstream of vita_tx_deframer in the tx chain.
//  - Buffers each incoming packet and compares its line count with the VITA header packet-size field.
//  - Forwards only complete, well-framed packets; drops malformed ones.
//  - The deframer therefore never sees truncated or overlong packets.

---
 rtl/vita_tx_pkt_checker.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/vita_tx_pkt_checker.sv
// Store-and-forward fifo36 packet checker ahead of the VITA tx deframer.
// Optional stats (drop_count, last_err) built when VITA_TX_PKT_CHECKER_STATS_EN is defined.
module vita_tx_pkt_checker #(
  parameter int BASE             = 0,
  parameter int DEPTH_LOG2       = 9,
  parameter bit USE_TRANS_HEADER = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [35:0] data_i,
  input  logic        src_rdy_i,
  output logic        dst_rdy_o,
  output logic [35:0] data_o,
  output logic        src_rdy_o,
  input  logic        dst_rdy_i,
  output logic [15:0] drop_count,
  output logic [2:0]  last_err
);

  localparam int AW  = DEPTH_LOG2 + 1;
  localparam int LIM = (1 << DEPTH_LOG2) - 1;

  typedef logic [AW-1:0] ptr_t;

  localparam ptr_t        ONE   = ptr_t'(1);
  localparam ptr_t        LIM_P = ptr_t'(LIM);
  localparam logic [16:0] LIM_S = 17'(LIM);

  localparam logic [2:0] ERR_NOSOF = 3'd1;
  localparam logic [2:0] ERR_LEN   = 3'd2;
  localparam logic [2:0] ERR_TRUNC = 3'd3;
  localparam logic [2:0] ERR_OVER  = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    BODY,
    DISCARD
  } state_t;

  state_t      state_q, state_d;
  ptr_t        wr_ptr, wr_ptr_d;
  ptr_t        pkt_start, pkt_start_d;
  ptr_t        commit_ptr, commit_d;
  ptr_t        rd_ptr;
  ptr_t        cnt_q, cnt_d;
  ptr_t        new_cnt;
  ptr_t        wr_addr;
  logic [16:0] exp_q, exp_d, exp_now, size;
  logic        pkt_check, chk_d;
  logic        check_en;
  logic        sof, eof;
  logic        full, xfer_in;
  logic        we, start;
  logic        drop, err_ev;
  logic [2:0]  err_code;

  logic [35:0] mem [1 << DEPTH_LOG2];
  logic [35:0] rd_data;
  logic        ram_vld, out_vld;
  logic        rd_en, load_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      check_en <= 1'b1;
    end else if (set_stb && set_addr == 8'(BASE)) begin
      check_en <= set_data[0];
    end
  end

  assign sof  = data_i[32];
  assign eof  = data_i[33];
  assign size = {1'b0, data_i[15:0]};
  assign full = (wr_ptr - rd_ptr) == LIM_P;

  // DISCARD sinks freely, but a new SOF there still needs a free slot
  assign dst_rdy_o = !reset &&
    (!full || (state_q == DISCARD && !sof));
  assign xfer_in = src_rdy_i && dst_rdy_o;

  assign new_cnt = cnt_q + ONE;
  assign exp_now = (state_q == HDR) ? size + 17'd1 : exp_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr;
    pkt_start_d = pkt_start;
    commit_d    = commit_ptr;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    chk_d       = pkt_check;
    we          = 1'b0;
    wr_addr     = wr_ptr;
    start       = 1'b0;
    drop        = 1'b0;
    err_ev      = 1'b0;
    err_code    = 3'd0;
    if (xfer_in) begin
      unique case (state_q)
        IDLE, DISCARD: begin
          if (sof) begin
            start = 1'b1;
          end else if (state_q == DISCARD) begin
            if (eof) state_d = IDLE;
          end else begin
            err_ev   = 1'b1;
            err_code = ERR_NOSOF;
          end
        end
        HDR, BODY: begin
          if (sof && pkt_check) begin
            drop     = 1'b1;
            err_ev   = 1'b1;
            err_code = ERR_TRUNC;
            start    = 1'b1;
          end else if (eof) begin
            if (!pkt_check || 17'(new_cnt) == exp_now) begin
              we          = 1'b1;
              wr_ptr_d    = wr_ptr + ONE;
              commit_d    = wr_ptr + ONE;
              pkt_start_d = wr_ptr + ONE;
            end else begin
              drop     = 1'b1;
              err_ev   = 1'b1;
              err_code = ERR_LEN;
              wr_ptr_d = pkt_start;
            end
            state_d = IDLE;
          end else if ((pkt_check && exp_now > LIM_S) ||
                       new_cnt >= LIM_P) begin
            // cannot fit in the buffer even when empty
            drop     = 1'b1;
            err_ev   = 1'b1;
            err_code = ERR_OVER;
            wr_ptr_d = pkt_start;
            state_d  = DISCARD;
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr + ONE;
            cnt_d    = new_cnt;
            exp_d    = exp_now;
            state_d  = BODY;
          end
        end
        default: ;
      endcase
      if (start) begin
        chk_d   = check_en;
        wr_addr = pkt_start;
        cnt_d   = ONE;
        exp_d   = size;
        if (eof) begin
          if (!check_en || (!USE_TRANS_HEADER && size == 17'd1)) begin
            we          = 1'b1;
            wr_ptr_d    = pkt_start + ONE;
            commit_d    = pkt_start + ONE;
            pkt_start_d = pkt_start + ONE;
          end else begin
            drop     = 1'b1;
            err_ev   = 1'b1;
            err_code = ERR_LEN;
            wr_ptr_d = pkt_start;
          end
          state_d = IDLE;
        end else if (check_en && !USE_TRANS_HEADER && size > LIM_S) begin
          drop     = 1'b1;
          err_ev   = 1'b1;
          err_code = ERR_OVER;
          wr_ptr_d = pkt_start;
          state_d  = DISCARD;
        end else begin
          we       = 1'b1;
          wr_ptr_d = pkt_start + ONE;
          state_d  = USE_TRANS_HEADER ? HDR : BODY;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      pkt_start  <= '0;
      commit_ptr <= '0;
      cnt_q      <= '0;
      exp_q      <= '0;
      pkt_check  <= 1'b1;
    end else if (clear) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      pkt_start  <= '0;
      commit_ptr <= '0;
      cnt_q      <= '0;
      exp_q      <= '0;
      pkt_check  <= check_en;
    end else begin
      state_q    <= state_d;
      wr_ptr     <= wr_ptr_d;
      pkt_start  <= pkt_start_d;
      commit_ptr <= commit_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      pkt_check  <= chk_d;
    end
  end

  // Only committed slots are read, so a read never hits the slot being written
  assign load_out = ram_vld && (!out_vld || dst_rdy_i);
  assign rd_en    = (rd_ptr != commit_ptr) && (!ram_vld || load_out);

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr[DEPTH_LOG2-1:0]] <= data_i;
    if (rd_en) rd_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      ram_vld <= 1'b0;
      out_vld <= 1'b0;
      data_o  <= '0;
    end else if (clear) begin
      rd_ptr  <= '0;
      ram_vld <= 1'b0;
      out_vld <= 1'b0;
      data_o  <= '0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + ONE;
      if (rd_en) ram_vld <= 1'b1;
      else if (load_out) ram_vld <= 1'b0;
      if (load_out) begin
        out_vld <= 1'b1;
        data_o  <= rd_data;
      end else if (dst_rdy_i) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign src_rdy_o = out_vld;

`ifdef VITA_TX_PKT_CHECKER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
      last_err   <= '0;
    end else if (clear) begin
      drop_count <= '0;
      last_err   <= '0;
    end else begin
      if (err_ev) last_err <= err_code;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end
`else
  logic stats_unused;
  assign stats_unused = ^{drop, err_ev, err_code};
  assign drop_count   = '0;
  assign last_err     = '0;
`endif

  logic cfg_unused;
  assign cfg_unused = ^set_data[31:1];

endmodule
